axi_ar_issuer: RTL

- Downstream consumer of araddr_fifo in the DDR frame-buffer read path.
- Pops 32-bit burst start addresses from the FIFO's read port (standard mode, rd_data valid one cycle after rd_en) and issues them as AXI4 AR transactions toward the DDR controller.
- Enforces a cap on outstanding read bursts by tracking R-channel last beats.
- Flags 4 KB-boundary violations and R-last underflow.

---
 rtl/axi_ar_issuer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi_ar_issuer.sv
// Pops burst start addresses from the frame-buffer address FIFO and issues
// them as AXI4 INCR read bursts, capping the number of bursts in flight.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   enable               allows new pops; an AR already in flight always completes
//   fifo_rd_*            FIFO read port (rd_data valid one cycle after rd_en)
//   m_axi_ar*            AXI4 AR channel (master side)
//   m_axi_r{valid,ready,last}  R channel, monitored only
//   outstanding          bursts issued whose rlast has not been seen yet
//   busy                 FSM active or bursts outstanding
//   err_4k, err_underflow  sticky error flags, cleared only by reset
module axi_ar_issuer #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned BEAT_BYTES      = 32,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    input  logic                  m_axi_rlast,
    output logic [3:0]            outstanding,
    output logic                  busy,
    output logic                  err_4k,
    output logic                  err_underflow
);

    localparam int unsigned SIZE_LOG2   = $clog2(BEAT_BYTES);
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    // Wide enough to hold a 12-bit page offset plus the largest legal burst.
    localparam int unsigned CHK_W       = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    can_pop;
    logic                    load_ar;
    logic                    ar_hs;
    logic                    r_hs;
    logic [ADDR_WIDTH-1:0]   addr_aligned;
    logic [CHK_W-1:0]        end_offset;
    logic                    crosses;

    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = 2'b01;

    assign can_pop = enable && !fifo_rd_empty && (outstanding < 4'(MAX_OUTSTANDING));
    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign r_hs    = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    assign busy    = (state != IDLE) || (outstanding != 4'd0);

    // Burst start is forced onto a beat boundary; the 4 KB check uses that address.
    assign addr_aligned = fifo_rd_data & ~ADDR_WIDTH'(BEAT_BYTES - 1);
    assign end_offset   = CHK_W'(addr_aligned[11:0]) + CHK_W'(BURST_BYTES);
    assign crosses      = end_offset > CHK_W'(4096);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (can_pop) state_next = FETCH;
            FETCH:   state_next = ISSUE;
            ISSUE:   if (m_axi_arready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: single-cycle pop strobe in IDLE, AR load in FETCH
    always_comb begin
        fifo_rd_en = 1'b0;
        load_ar    = 1'b0;
        case (state)
            IDLE:    fifo_rd_en = can_pop;
            FETCH:   load_ar    = 1'b1;
            default: ;
        endcase
    end

    // AR channel registers and 4 KB flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_arid    <= '0;
            err_4k        <= 1'b0;
        end else if (load_ar) begin
            m_axi_araddr  <= addr_aligned;
            m_axi_arvalid <= 1'b1;
            if (crosses) err_4k <= 1'b1;
        end else if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_arid    <= m_axi_arid + ID_WIDTH'(1);
        end
    end

    // Outstanding-burst counter; a simultaneous issue and completion cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding   <= 4'd0;
            err_underflow <= 1'b0;
        end else if (ar_hs && !r_hs) begin
            outstanding <= outstanding + 4'd1;
        end else if (r_hs && !ar_hs) begin
            if (outstanding != 4'd0) begin
                outstanding <= outstanding - 4'd1;
            end else begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
